// File: rtl/mux_21_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mux_21_arbiter                                         |
// | Description : Two-source round-robin packet arbiter that owns the    |
// |               select line of a 2:1 output mux and passes the ready   |
// |               handshake back to the granted source.                  |
// | Options     : ARB_WATCHDOG_EN - stall watchdog that force-releases   |
// |               a grant after TIMEOUT cycles without an accepted beat. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mux_21_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v0_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic             l0_i,
  output logic             r0_o,
  input  logic             v1_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic             l1_i,
  output logic             r1_o,
  output logic             y_valid_o,
  output logic [WIDTH-1:0] y_data_o,
  output logic             y_last_o,
  input  logic             y_ready_i,
  output logic             sel_o,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t st_q, st_d;
  logic   prio_q, prio_d;
  logic   sel_q, sel_d;

  // Signals describing the currently granted source and the other one.
  logic   vn_w;
  logic   ln_w;
  logic   vo_w;
  logic   accept_w;
  logic   pkt_end_w;
  logic   wd_fire_w;

  assign busy_o   = (st_q == G0) || (st_q == G1);
  assign vn_w     = (st_q == G1) ? v1_i : v0_i;
  assign ln_w     = (st_q == G1) ? l1_i : l0_i;
  assign vo_w     = (st_q == G1) ? v0_i : v1_i;
  assign accept_w = busy_o && vn_w && y_ready_i;
  // A packet ends on an accepted last beat, or when the watchdog forces it.
  assign pkt_end_w = (accept_w && ln_w) || wd_fire_w;
  assign sel_o     = sel_q;

  // Output mux: steer the granted source straight through, idle drives zeros.
  always_comb begin
    y_valid_o = 1'b0;
    y_data_o  = '0;
    y_last_o  = 1'b0;
    r0_o      = 1'b0;
    r1_o      = 1'b0;
    case (st_q)
      G0: begin
        y_valid_o = v0_i;
        y_data_o  = d0_i;
        y_last_o  = l0_i;
        r0_o      = y_ready_i;
      end
      G1: begin
        y_valid_o = v1_i;
        y_data_o  = d1_i;
        y_last_o  = l1_i;
        r1_o      = y_ready_i;
      end
      default: begin
      end
    endcase
  end

  // Next-state, round-robin pointer and select update.
  always_comb begin
    st_d   = st_q;
    prio_d = prio_q;
    case (st_q)
      IDLE: begin
        if (v0_i && v1_i) begin
          st_d = prio_q ? G1 : G0;
        end else if (v0_i) begin
          st_d = G0;
        end else if (v1_i) begin
          st_d = G1;
        end
      end
      G0, G1: begin
        if (pkt_end_w) begin
          // Favour the other source on the next tie.
          prio_d = (st_q == G0);
          if (vo_w) begin
            st_d = (st_q == G0) ? G1 : G0;
          end else if (vn_w) begin
            st_d = st_q;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: st_d = IDLE;
    endcase

    // Select follows the grant and holds its last value while idle.
    case (st_d)
      G0:      sel_d = 1'b0;
      G1:      sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase
  end

  // State, priority pointer and select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      prio_q <= 1'b0;
      sel_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      prio_q <= prio_d;
      sel_q  <= sel_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  assign wd_fire_w = busy_o && (wd_cnt_q == CNT_MAX);
  assign timeout_o = wd_fire_w;

  // Stall counter: counts granted cycles without progress, clears on any
  // accepted beat, while idle, and on the forced release itself.
  always_comb begin
    wd_cnt_d = wd_cnt_q + CNT_W'(1);
    if (!busy_o || accept_w || wd_fire_w) begin
      wd_cnt_d = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_fire_w = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/mux_21_arbiter.md
# mux_21_arbiter

Two-requester round-robin arbiter that shares one output channel through a 2:1 mux. Each source presents valid/data/last beats. The arbiter grants one source per packet, steers the mux select and passes the ready handshake back to the granted source. It sits in front of the `mux_21` datapath and owns its select line; no other logic drives `sel`.

## Interface
- `WIDTH`, default 8: data width of each source and of the output.
- `TIMEOUT`, default 16: stall cycles before a forced grant release. Only used with `ARB_WATCHDOG_EN`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `v0`, in, 1: source 0 beat valid.
- `d0`, in, `WIDTH`: source 0 data.
- `l0`, in, 1: source 0 last beat of packet.
- `r0`, out, 1: ready to source 0.
- `v1`, `d1`, `l1`, `r1`: same set for source 1.
- `y_valid`, out, 1: output beat valid.
- `y_data`, out, `WIDTH`: output data.
- `y_last`, out, 1: output last flag.
- `y_ready`, in, 1: downstream ready.
- `sel`, out, 1: registered mux select (0 = source 0, 1 = source 1).
- `busy`, out, 1: a grant is active.
- `timeout`, out, 1: one-cycle pulse on forced release. Tied 0 without `ARB_WATCHDOG_EN`.

## Operation
- State register `st` ∈ {`IDLE`, `G0`, `G1`}. `prio` is a 1-bit round-robin pointer naming the source favoured on a tie.
- **IDLE**
  - Only `v0` → `G0`; only `v1` → `G1`.
  - Both valid → `G[prio]`.
  - Neither valid → stay in `IDLE`.
- **Gn** (n = granted source)
  - `y_valid` = `vn`, `y_data` = `dn`, `y_last` = `ln`.
  - `rn` = `y_ready`; ready to the other source = 0.
  - Beat accepted when `vn && y_ready`.
  - Accepted beat with `ln` = 1 ends the packet, and `prio` ← other source.
  - Next state after packet end:
    - `G[other]` if other source's `v` = 1;
    - else `Gn` if `vn` = 1;
    - else `IDLE`.
  - Non-last or unaccepted beats: stay in `Gn`.
- `sel` ← n on entry to `Gn`. It holds its value in `IDLE`.
- `busy` = 1 in `G0`/`G1`.
- In `IDLE`: `y_valid`, `y_last`, `r0`, `r1` = 0, and `y_data` = 0.
- A grant is never revoked mid-packet except by the watchdog or `rst`.
- Source valid dropping mid-packet: the grant is held and `y_valid` follows `vn`.
- Width rules: `y_data` is exactly `WIDTH` bits, with no extension or truncation.

## Timing
- Reset values: `st` = `IDLE`, `prio` = 0, `sel` = 0, watchdog count = 0.
  - All outputs 0 from the cycle after the `rst` edge.
  - `rst` mid-packet aborts the grant at that edge; no beat completes in that cycle.
- Arbitration latency: a valid seen in `IDLE` at edge k gives `y_valid` at cycle k+1.
- Handoff latency: back-to-back packets from alternating sources have zero bubble. The last beat accepted at edge k makes the other source granted in cycle k+1.
- `y_valid`/`y_data`/`y_last`/`rn` are combinational from `st` and source inputs, with no extra register stage.
- `rn` is combinational from `y_ready` (pass-through).
- Simultaneous `v0`/`v1` rising in `IDLE` are resolved by `prio`. `prio` after reset = 0, so source 0 wins the first tie.

## Configuration
- Macro: `ARB_WATCHDOG_EN`.
- **Defined:**
  - A counter of `$clog2(TIMEOUT+1)` bits increments each cycle in `Gn` with no accepted beat.
  - It clears on any accepted beat and in `IDLE`.
  - When it reaches `TIMEOUT`, the next edge applies the packet-end rule (same as an accepted last beat, `prio` included).
  - `timeout` pulses 1 for that one cycle, and the counter clears.
- **Undefined:** no counter; the grant is held indefinitely; `timeout` is constant 0.

## Test plan
- **Reset:** assert `rst` 2 cycles with `v0`=`v1`=1 → all outputs 0, `sel`=0. First release cycle: `st`=`IDLE`; next cycle `G0`, `y_valid`=1, `y_data`=`d0`.
- **Single source:** `v1`=1, `d1`=8'hA5, 3-beat packet, `y_ready`=1 → `y_data`=A5 on 3 consecutive cycles, `r0`=0 throughout, `sel`=1, `busy`=1, then `IDLE`.
- **Tie and round robin:** `v0`=`v1`=1 continuously, 2-beat packets → grants alternate 0,1,0,1 with zero idle cycles between packets.
- **Backpressure:** `y_ready`=0 for 5 cycles mid-packet → `y_data`/`y_last` stable, `r0`=0, and the grant is held. `y_ready`=1 → transfer resumes.
- **Watchdog (`ARB_WATCHDOG_EN`, `TIMEOUT`=4):**
  - `G0` with `v0`=0 and `v1`=1 → after 4 stall cycles `timeout`=1 for 1 cycle, then `G1`.
  - Same stimulus without the macro → stays in `G0` for 50 cycles, `timeout`=0.
- **Reset mid-packet:** `rst` asserted during beat 2 of 4 → `IDLE` next cycle, `prio`=0, no `y_valid`.
